// File: rtl/upsample2x_with_memory_control_pkg.sv
// rtl/upsample2x_with_memory_control_pkg.sv - shared layer codes, sizes, widths and FSM encoding
package upsample2x_with_memory_control_pkg;

    localparam int input_map_address_datawidth  = 11;
    localparam int output_map_address_datawidth = 13;
    localparam int number_datawidth             = 16;
    localparam int size_datawidth               = 7;
    localparam int STATE_DATAWIDTH              = 4;

    localparam logic [STATE_DATAWIDTH-1:0] AVG1_STATE = 4'd7;
    localparam logic [STATE_DATAWIDTH-1:0] AVG2_STATE = 4'd8;
    localparam logic [STATE_DATAWIDTH-1:0] AVG3_STATE = 4'd9;
    localparam logic [STATE_DATAWIDTH-1:0] UP1_STATE  = 4'd10;
    localparam logic [STATE_DATAWIDTH-1:0] UP2_STATE  = 4'd11;
    localparam logic [STATE_DATAWIDTH-1:0] UP3_STATE  = 4'd12;

    localparam logic [size_datawidth-1:0] UP1_INPUT_SIZE = 7'd7;
    localparam logic [size_datawidth-1:0] UP2_INPUT_SIZE = 7'd18;
    localparam logic [size_datawidth-1:0] UP3_INPUT_SIZE = 7'd40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } up_fsm_t;

    // Unknown layer codes fall back to the smallest map.
    function automatic logic [size_datawidth-1:0] size_for_state(
        input logic [STATE_DATAWIDTH-1:0] code
    );
        case (code)
            UP1_STATE: return UP1_INPUT_SIZE;
            UP2_STATE: return UP2_INPUT_SIZE;
            UP3_STATE: return UP3_INPUT_SIZE;
            default:   return UP1_INPUT_SIZE;
        endcase
    endfunction

endpackage

// File: rtl/upsample2x_with_memory_control_if.sv
// rtl/upsample2x_with_memory_control_if.sv - source-read / destination-write BRAM bus
interface upsample2x_with_memory_control_if
    import upsample2x_with_memory_control_pkg::*;
();

    logic [number_datawidth-1:0]             BRAM_Up_In;
    logic [input_map_address_datawidth-1:0]  BRAM_Up_In_Address;
    logic [number_datawidth-1:0]             BRAM_Up_Out;
    logic [output_map_address_datawidth-1:0] BRAM_Up_Out_Address;
    logic                                    wr_ena;

    modport master (
        input  BRAM_Up_In,
        output BRAM_Up_In_Address,
        output BRAM_Up_Out,
        output BRAM_Up_Out_Address,
        output wr_ena
    );

    modport slave (
        output BRAM_Up_In,
        input  BRAM_Up_In_Address,
        input  BRAM_Up_Out,
        input  BRAM_Up_Out_Address,
        input  wr_ena
    );

endinterface

// File: rtl/upsample2x_with_memory_control_addr_gen.sv
// rtl/upsample2x_with_memory_control_addr_gen.sv - incremental raster address generator (no multiply/divide)
module upsample_addr_gen
    import upsample2x_with_memory_control_pkg::*;
(
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic                                    clear,
    input  logic                                    advance,
    input  logic [size_datawidth-1:0]               n,
    output logic [input_map_address_datawidth-1:0]  src_addr,
    output logic [output_map_address_datawidth-1:0] dst_addr,
    output logic                                    last
);

    logic [size_datawidth-1:0]               row;
    logic [size_datawidth-1:0]               col;
    logic [input_map_address_datawidth-1:0]  src_col;
    logic [input_map_address_datawidth-1:0]  src_row_base;
    logic [output_map_address_datawidth-1:0] dst;
    logic [size_datawidth-1:0]               two_n_m1;
    logic [input_map_address_datawidth-1:0]  n_ext;
    logic                                    row_end;

    assign two_n_m1 = n + n - 7'd1;
    assign n_ext    = {{(input_map_address_datawidth-size_datawidth){1'b0}}, n};
    assign row_end  = (col == two_n_m1);

    assign src_addr = src_col;
    assign dst_addr = dst;
    assign last     = row_end && (row == two_n_m1);

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            row          <= '0;
            col          <= '0;
            src_col      <= '0;
            src_row_base <= '0;
            dst          <= '0;
        end else if (advance) begin
            dst <= dst + 13'd1;
            if (row_end) begin
                col <= '0;
                row <= row + 7'd1;
                // Odd output rows close a source row: move the base down one source row.
                if (row[0]) begin
                    src_row_base <= src_row_base + n_ext;
                    src_col      <= src_row_base + n_ext;
                end else begin
                    src_col <= src_row_base;
                end
            end else begin
                col <= col + 7'd1;
                if (col[0]) begin
                    src_col <= src_col + 11'd1;
                end
            end
        end
    end

endmodule

// File: rtl/upsample2x_with_memory_control.sv
// rtl/upsample2x_with_memory_control.sv - 2x nearest-neighbour float16 map upsampler between BRAMs
module upsample2x_with_memory_control
    import upsample2x_with_memory_control_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [STATE_DATAWIDTH-1:0] state,
    upsample2x_with_memory_control_if.master bram,
    output logic                       busy,
    output logic                       done
);

    up_fsm_t                                 fsm;
    logic [size_datawidth-1:0]               n_q;
    logic                                    last_q;
    logic                                    issue;
    logic                                    clear;
    logic                                    gen_last;
    logic [input_map_address_datawidth-1:0]  src_addr;
    logic [output_map_address_datawidth-1:0] dst_addr;
    logic                                    wr_ena_q;
    logic [output_map_address_datawidth-1:0] out_addr_q;

    assign issue = (fsm == ST_READ) && !last_q;
    assign clear = (fsm == ST_IDLE) && start;

    upsample_addr_gen u_addr_gen (
        .clk      (clk),
        .resetn   (reset),
        .clear    (clear),
        .advance  (issue),
        .n        (n_q),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .last     (gen_last)
    );

    assign bram.BRAM_Up_In_Address  = issue ? src_addr : '0;
    assign bram.BRAM_Up_Out_Address = out_addr_q;
    assign bram.wr_ena              = wr_ena_q;
    // Read data arrives exactly when its registered write strobe does.
    assign bram.BRAM_Up_Out         = wr_ena_q ? bram.BRAM_Up_In : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm        <= ST_IDLE;
            n_q        <= UP1_INPUT_SIZE;
            last_q     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_ena_q   <= 1'b0;
            out_addr_q <= '0;
        end else begin
            wr_ena_q <= issue;
            done     <= 1'b0;
            if (issue) begin
                out_addr_q <= dst_addr;
            end
            case (fsm)
                ST_IDLE: begin
                    if (start) begin
                        fsm        <= ST_READ;
                        busy       <= 1'b1;
                        n_q        <= size_for_state(state);
                        last_q     <= 1'b0;
                        out_addr_q <= '0;
                    end
                end
                ST_READ: begin
                    // last_q holds READ one more cycle so the final write lands before FLUSH.
                    if (last_q) begin
                        fsm <= ST_FLUSH;
                    end else if (gen_last) begin
                        last_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    fsm  <= ST_DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                ST_DONE: begin
                    fsm <= ST_IDLE;
                end
                default: begin
                    fsm <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upsample2x_with_memory_control.sv
// tb/tb_upsample2x_with_memory_control.sv - self-checking bench for the 2x upsampler
module tb_upsample2x_with_memory_control;
    import upsample2x_with_memory_control_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] state;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    upsample2x_with_memory_control_if bus ();

    upsample2x_with_memory_control dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .state (state),
        .bram  (bus),
        .busy  (busy),
        .done  (done)
    );

    logic [15:0] src_mem [0:2047];
    logic [15:0] dst_mem [0:8191];

    always @(posedge clk) bus.BRAM_Up_In <= src_mem[bus.BRAM_Up_In_Address];
    always @(posedge clk) if (bus.wr_ena) dst_mem[bus.BRAM_Up_Out_Address] <= bus.BRAM_Up_Out;

    int n_checks = 0;
    int n_pass   = 0;

    int r_writes, r_errs, r_done_cyc, r_first_cyc, r_last_cyc;
    int r_last_wr, r_last_rd, r_busy_errs;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Nearest neighbour: output (row, col) takes source (row/2, col/2).
    function automatic logic [15:0] expected_pixel(input int addr, input int n);
        int row;
        int col;
        row = addr / (2 * n);
        col = addr % (2 * n);
        return src_mem[(row / 2) * n + (col / 2)];
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 2048; i++) src_mem[i] = 16'($urandom);
        src_mem[1] = 16'h7E00;
        src_mem[2] = 16'h7C00;
        src_mem[3] = 16'h0001;
        src_mem[4] = 16'hFC00;
    endtask

    task automatic run_map(input logic [3:0] st, input int n, input int busy_start_cyc,
                           input bit start_on_done, input int rst_at_write);
        int prev_rd;
        int budget;
        r_writes = 0; r_errs = 0; r_done_cyc = -1; r_first_cyc = -1; r_last_cyc = -1;
        r_last_wr = -1; r_last_rd = -1; r_busy_errs = 0;
        budget = 4 * n * n + 20;
        prev_rd = 0;
        state = st;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            start = 1'b0;
            if (cyc == busy_start_cyc) begin
                start = 1'b1;
                state = UP2_STATE;
            end
            if (bus.wr_ena === 1'b1) begin
                if (r_writes == 0) r_first_cyc = cyc;
                r_last_cyc = cyc;
                if (int'(bus.BRAM_Up_Out_Address) != r_writes) r_errs++;
                if (bus.BRAM_Up_Out !== expected_pixel(r_writes, n)) r_errs++;
                r_last_wr = int'(bus.BRAM_Up_Out_Address);
                r_last_rd = prev_rd;
                r_writes++;
            end
            prev_rd = int'(bus.BRAM_Up_In_Address);
            if (done === 1'b1) begin
                r_done_cyc = cyc;
                if (busy !== 1'b0) r_busy_errs++;
                if (start_on_done) begin
                    start = 1'b1;
                    state = UP2_STATE;
                end
                step();
                start = 1'b0;
                break;
            end
            if (busy !== 1'b1) r_busy_errs++;
            if (rst_at_write >= 0 && r_writes == rst_at_write) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
                break;
            end
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        state = UP3_STATE;
        repeat (3) step();
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (bus.wr_ena !== 1'b0) $display("FAIL reset_wr_ena: got %b want 0", bus.wr_ena); else n_pass++;
        n_checks++; if (bus.BRAM_Up_In_Address !== 11'd0)
            $display("FAIL reset_rd_addr: got %0d want 0", bus.BRAM_Up_In_Address); else n_pass++;
        n_checks++; if (bus.BRAM_Up_Out_Address !== 13'd0)
            $display("FAIL reset_wr_addr: got %0d want 0", bus.BRAM_Up_Out_Address); else n_pass++;
        n_checks++; if (bus.BRAM_Up_Out !== 16'd0)
            $display("FAIL reset_data: got %h want 0", bus.BRAM_Up_Out); else n_pass++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_up1();
        fill_random();
        for (int k = 0; k < 49; k++) src_mem[k] = 16'h3C00 + 16'(k);
        run_map(UP1_STATE, 7, -1, 1'b0, -1);
        n_checks++; if (r_writes != 196) $display("FAIL up1_writes: got %0d want 196", r_writes); else n_pass++;
        n_checks++; if (r_errs != 0) $display("FAIL up1_data_addr: got %0d errors want 0", r_errs); else n_pass++;
        n_checks++; if (r_done_cyc != 199) $display("FAIL up1_done_cycle: got %0d want 199", r_done_cyc); else n_pass++;
        n_checks++; if (r_first_cyc != 2) $display("FAIL up1_first_write: got %0d want 2", r_first_cyc); else n_pass++;
        n_checks++; if (r_last_cyc != 197) $display("FAIL up1_last_write: got %0d want 197", r_last_cyc); else n_pass++;
        n_checks++; if (r_busy_errs != 0) $display("FAIL up1_busy: got %0d errors want 0", r_busy_errs); else n_pass++;
        n_checks++; if (dst_mem[0] !== 16'h3C00 || dst_mem[1] !== 16'h3C00 || dst_mem[14] !== 16'h3C00 || dst_mem[15] !== 16'h3C00)
            $display("FAIL up1_block0: got %h %h %h %h want 3c00", dst_mem[0], dst_mem[1], dst_mem[14], dst_mem[15]);
        else n_pass++;
        n_checks++; if (dst_mem[2] !== 16'h3C01) $display("FAIL up1_dst2: got %h want 3c01", dst_mem[2]); else n_pass++;
        n_checks++; if (dst_mem[195] !== 16'h3C30) $display("FAIL up1_dst195: got %h want 3c30", dst_mem[195]); else n_pass++;
    endtask

    task automatic test_up3();
        fill_random();
        run_map(UP3_STATE, 40, -1, 1'b0, -1);
        n_checks++; if (r_writes != 6400) $display("FAIL up3_writes: got %0d want 6400", r_writes); else n_pass++;
        n_checks++; if (r_errs != 0) $display("FAIL up3_data_addr: got %0d errors want 0", r_errs); else n_pass++;
        n_checks++; if (r_last_rd != 1599) $display("FAIL up3_last_rd: got %0d want 1599", r_last_rd); else n_pass++;
        n_checks++; if (r_last_wr != 6399) $display("FAIL up3_last_wr: got %0d want 6399", r_last_wr); else n_pass++;
        n_checks++; if (r_done_cyc != 6403) $display("FAIL up3_done_cycle: got %0d want 6403", r_done_cyc); else n_pass++;
        n_checks++; if (dst_mem[80] !== src_mem[0]) $display("FAIL up3_dst80: got %h want %h", dst_mem[80], src_mem[0]); else n_pass++;
        n_checks++; if (dst_mem[160] !== src_mem[40]) $display("FAIL up3_dst160: got %h want %h", dst_mem[160], src_mem[40]); else n_pass++;
    endtask

    task automatic test_invalid_state();
        fill_random();
        run_map(4'd3, 7, -1, 1'b0, -1);
        n_checks++; if (r_writes != 196) $display("FAIL inv_writes: got %0d want 196", r_writes); else n_pass++;
        n_checks++; if (r_errs != 0) $display("FAIL inv_data_addr: got %0d errors want 0", r_errs); else n_pass++;
        n_checks++; if (r_done_cyc != 199) $display("FAIL inv_done_cycle: got %0d want 199", r_done_cyc); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int extra;
        fill_random();
        run_map(UP1_STATE, 7, 20, 1'b1, -1);
        n_checks++; if (r_writes != 196) $display("FAIL busy_writes: got %0d want 196", r_writes); else n_pass++;
        n_checks++; if (r_errs != 0) $display("FAIL busy_data_addr: got %0d errors want 0", r_errs); else n_pass++;
        n_checks++; if (r_done_cyc != 199) $display("FAIL busy_done_cycle: got %0d want 199", r_done_cyc); else n_pass++;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b0 || done !== 1'b0 || bus.wr_ena !== 1'b0) extra++;
            step();
        end
        n_checks++; if (extra != 0) $display("FAIL busy_after_done: got %0d active cycles want 0", extra); else n_pass++;
    endtask

    task automatic test_reset_mid_map();
        int extra;
        fill_random();
        run_map(UP2_STATE, 18, -1, 1'b0, 50);
        n_checks++; if (r_writes != 50) $display("FAIL midrst_writes_before: got %0d want 50", r_writes); else n_pass++;
        n_checks++; if (bus.wr_ena !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midrst_ctrl: got wr_ena=%b busy=%b done=%b want 0", bus.wr_ena, busy, done); else n_pass++;
        n_checks++; if (bus.BRAM_Up_In_Address !== 11'd0 || bus.BRAM_Up_Out_Address !== 13'd0)
            $display("FAIL midrst_addr: got rd=%0d wr=%0d want 0", bus.BRAM_Up_In_Address, bus.BRAM_Up_Out_Address);
        else n_pass++;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || bus.wr_ena !== 1'b0) extra++;
            step();
        end
        n_checks++; if (extra != 0) $display("FAIL midrst_quiet: got %0d active cycles want 0", extra); else n_pass++;
        run_map(UP2_STATE, 18, -1, 1'b0, -1);
        n_checks++; if (r_writes != 1296) $display("FAIL midrst_rerun_writes: got %0d want 1296", r_writes); else n_pass++;
        n_checks++; if (r_errs != 0) $display("FAIL midrst_rerun_data: got %0d errors want 0", r_errs); else n_pass++;
        n_checks++; if (r_done_cyc != 1299) $display("FAIL midrst_rerun_done: got %0d want 1299", r_done_cyc); else n_pass++;
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_map(UP2_STATE, 18, -1, 1'b0, -1);
        n_checks++; if (r_writes != 1296 || r_errs != 0)
            $display("FAIL b2b_first: got writes=%0d errs=%0d want 1296/0", r_writes, r_errs); else n_pass++;
        run_map(UP1_STATE, 7, -1, 1'b0, -1);
        n_checks++; if (r_writes != 196) $display("FAIL b2b_second_writes: got %0d want 196", r_writes); else n_pass++;
        n_checks++; if (r_errs != 0) $display("FAIL b2b_second_data: got %0d errors want 0", r_errs); else n_pass++;
        n_checks++; if (r_first_cyc != 2 || r_done_cyc != 199)
            $display("FAIL b2b_second_timing: got first=%0d done=%0d want 2/199", r_first_cyc, r_done_cyc); else n_pass++;
        n_checks++; if (dst_mem[15] !== src_mem[0] || dst_mem[16] !== src_mem[1])
            $display("FAIL b2b_second_repl: got %h %h want %h %h", dst_mem[15], dst_mem[16], src_mem[0], src_mem[1]);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        state = 4'd0;
        for (int i = 0; i < 2048; i++) src_mem[i] = 16'd0;
        step();
        test_reset();
        test_up1();
        test_up3();
        test_invalid_state();
        test_start_while_busy();
        test_reset_mid_map();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/upsample2x_with_memory_control.md
Name: upsample2x_with_memory_control

Overview:
- 2x nearest-neighbour upsampler for float16 feature maps. It works in the opposite direction to the average-pool stage.
- It reads an N x N map from a source BRAM with 1-cycle read latency, in raster order. It writes a 2N x 2N map to a destination BRAM.
- Each source pixel is replicated into a 2x2 block.
- It sits between a pooled/low-resolution layer buffer and the next convolution's input BRAM. The top-level controller selects the layer via `state`.

Parameters:
- input_map_address_datawidth, 11, source (N x N) BRAM address width
- output_map_address_datawidth, 13, destination (2N x 2N) BRAM address width
- number_datawidth, 16, float16 word width
- size_datawidth, 7, width of size/row/column counters
- STATE_DATAWIDTH, 4, width of `state`
- UP1_STATE, 10, layer code selecting size 7 -> 14
- UP2_STATE, 11, layer code selecting size 18 -> 36
- UP3_STATE, 12, layer code selecting size 40 -> 80
- UP1_INPUT_SIZE, 7, N for UP1
- UP2_INPUT_SIZE, 18, N for UP2
- UP3_INPUT_SIZE, 40, N for UP3

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- start  in  1  1-cycle pulse; begins one map when idle
- state  in  STATE_DATAWIDTH  layer code; sampled on accepted start
- BRAM_Up_In  in  number_datawidth  source BRAM read data; valid 1 cycle after address
- BRAM_Up_In_Address  out  input_map_address_datawidth  source read address
- BRAM_Up_Out  out  number_datawidth  destination write data
- BRAM_Up_Out_Address  out  output_map_address_datawidth  destination write address
- wr_ena  out  1  destination write strobe
- busy  out  1  high from accepted start until done
- done  out  1  1-cycle pulse after last write

Behaviour:
- Reset is sampled on posedge clk only. While reset=0:
  - FSM goes to IDLE.
  - All outputs and counters go to 0: addresses, wr_ena, busy, done, BRAM_Up_Out.
  - A reset mid-map aborts the map immediately, with no further writes and no done pulse.
- Size select is latched on accepted start. The latched N stays fixed for the whole map.
  - state == UP1_STATE: N = 7.
  - state == UP2_STATE: N = 18.
  - state == UP3_STATE: N = 40.
  - Any other value: N = UP1_INPUT_SIZE.
- FSM states:
  - IDLE: start=1 -> READ, busy <= 1. Otherwise stay in IDLE.
  - READ: one destination pixel per cycle. Output row r and column c step in raster order from 0 to 2N-1.
  - BRAM_Up_In_Address = (r>>1)*N + (c>>1). It is generated incrementally with no multiplier or divider:
    - An src_col counter increments when c is odd.
    - A src_row_base register adds N when r is odd and c = 2N-1.
    - When c = 2N-1 and r is even, src_col rewinds to src_row_base.
  - After the pixel r = c = 2N-1 has issued: READ -> FLUSH.
  - FLUSH: one cycle to absorb the BRAM latency -> DONE.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- Write pipeline (fixed 1-cycle latency):
  - Destination address r*2N + c is registered one cycle after its read address.
  - wr_ena is registered alongside it.
  - BRAM_Up_Out is driven from BRAM_Up_In in the cycle that wr_ena=1.
  - The destination address increments by 1 per write, 0 .. 4N^2-1, with no gaps.
  - wr_ena is high for exactly 4N^2 consecutive cycles.
- Timing:
  - The first write occurs 2 cycles after the start cycle.
  - Total from start to done is 4N^2 + 3 cycles.
- Data handling: data passes bit-exact, with no float arithmetic. NaN/Inf/denormal patterns are copied unchanged.
- start is ignored while busy=1, including in FLUSH and DONE. A start in the same cycle as done is ignored. A new map requires start after return to IDLE.
- Outside READ/FLUSH:
  - wr_ena=0.
  - BRAM_Up_In_Address holds 0.
  - BRAM_Up_Out_Address holds its last value; it is reset to 0 on the next accepted start.

Decomposition:
- Shared package holds:
  - Layer state codes UPx_STATE, alongside the existing AVGx codes.
  - Layer size constants.
  - Address width constants.
  - FSM state encoding: IDLE, READ, FLUSH, DONE.
- One natural sub-module, upsample_addr_gen. It contains the r/c/src_col/src_row_base counters and produces the source address, destination address and last-pixel flag.
- The top module holds the FSM, the latency pipeline and the size select.

Test Plan:
- UP1 map: reset, then source BRAM model with word k = 16'h3C00 + k (k = 0..48), then start with state=UP1_STATE.
  - 196 writes follow, at destination addresses 0..195.
  - Destination 0, 1, 14 and 15 all carry 16'h3C00.
  - Destination 2 carries 16'h3C01.
  - Destination 195 carries 16'h3C30.
  - done arrives 199 cycles after start.
- UP3 size check: start with state=UP3_STATE.
  - Exactly 6400 wr_ena cycles occur.
  - The last read address is 1599 and the last write address is 6399.
  - Destination 80 carries source word 0.
  - Destination 160 carries source word 40.
- Invalid state: start with state=4'd3.
  - Behaves as UP1: 196 writes.
- Start while busy: pulse start during READ with state=UP2_STATE, and again in the done cycle.
  - Neither start is accepted.
  - Size stays N=7 and exactly one done pulse occurs.
- Reset mid-map: drive reset=0 for 1 cycle at write 50 of UP2.
  - The next cycle has wr_ena=0, busy=0 and addresses 0.
  - No done pulse.
  - A subsequent start produces a complete 1296-write map.
- Back-to-back maps: start UP2 then UP1, with start asserted in the cycle after done.
  - The second map begins at destination address 0 with correct N=7 replication.
